// File: rtl/wb_biu_arbiter.sv
// wb_biu_arbiter: round-robin sharing of the single Wishbone BIU between
// cache-line requesters. Each transaction passes through IDLE -> BUSY -> RELEASE,
// which leaves the BIU at least one idle cycle between transactions.
module wb_biu_arbiter #(
  parameter int OPTN_ADDR_WIDTH   = 32,
  parameter int OPTN_DC_LINE_SIZE = 32,
  parameter int OPTN_BIU_NUM_REQ  = 2,
  parameter int DC_LINE_WIDTH     = OPTN_DC_LINE_SIZE * 8,
  parameter int REQ_IDX_WIDTH     = $clog2(OPTN_BIU_NUM_REQ)
) (
  input  logic                                        i_wb_clk,
  input  logic                                        i_wb_rst,
  input  logic [OPTN_BIU_NUM_REQ-1:0]                 i_req_en,
  input  logic [OPTN_BIU_NUM_REQ-1:0]                 i_req_we,
  input  logic [OPTN_BIU_NUM_REQ*OPTN_ADDR_WIDTH-1:0] i_req_addr,
  input  logic [OPTN_BIU_NUM_REQ*DC_LINE_WIDTH-1:0]   i_req_data,
  output logic [OPTN_BIU_NUM_REQ-1:0]                 o_req_gnt,
  output logic [OPTN_BIU_NUM_REQ-1:0]                 o_req_done,
  output logic [DC_LINE_WIDTH-1:0]                    o_req_data,
  output logic                                        o_biu_en,
  output logic                                        o_biu_we,
  output logic [OPTN_ADDR_WIDTH-1:0]                  o_biu_addr,
  output logic [DC_LINE_WIDTH-1:0]                    o_biu_data,
  input  logic [DC_LINE_WIDTH-1:0]                    i_biu_data,
  input  logic                                        i_biu_busy,
  input  logic                                        i_biu_done
);

  localparam int unsigned NUM_REQ_U = OPTN_BIU_NUM_REQ;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t                   state;
  logic [REQ_IDX_WIDTH-1:0] gnt_idx;
  logic [REQ_IDX_WIDTH-1:0] last_idx;
  logic [REQ_IDX_WIDTH-1:0] cand_idx;
  logic [REQ_IDX_WIDTH-1:0] pick_idx;
  logic                     pick_valid;

  // Circular scan starting just after the most recent grant; first requester found wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand_idx   = '0;
    for (int unsigned i = 1; i <= NUM_REQ_U; i++) begin
      cand_idx = REQ_IDX_WIDTH'((32'(last_idx) + i) % NUM_REQ_U);
      if (!pick_valid && i_req_en[cand_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // Transaction sequencing; a BIU still reporting busy/done holds off a new grant.
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      state    <= IDLE;
      gnt_idx  <= '0;
      last_idx <= REQ_IDX_WIDTH'(OPTN_BIU_NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid && !i_biu_busy && !i_biu_done) begin
            gnt_idx  <= pick_idx;
            last_idx <= pick_idx;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (i_biu_done && !i_req_en[gnt_idx]) begin
            state <= RELEASE;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // BIU request mux and completion routing, active only while BUSY.
  always_comb begin
    o_req_gnt  = '0;
    o_req_done = '0;
    o_req_data = i_biu_data;
    o_biu_en   = 1'b0;
    o_biu_we   = 1'b0;
    o_biu_addr = '0;
    o_biu_data = '0;
    if (state == BUSY) begin
      o_biu_en            = 1'b1;
      o_req_gnt[gnt_idx]  = 1'b1;
      o_req_done[gnt_idx] = i_biu_done;
      o_biu_we            = i_req_we[gnt_idx];
      o_biu_addr          = i_req_addr[32'(gnt_idx) * OPTN_ADDR_WIDTH +: OPTN_ADDR_WIDTH];
      o_biu_data          = i_req_data[32'(gnt_idx) * DC_LINE_WIDTH +: DC_LINE_WIDTH];
    end
  end

  // The granted requester must hold its request until the BIU reports done.
  a_hold_en_until_done: assert property (
    @(posedge i_wb_clk) disable iff (i_wb_rst)
      (state == BUSY && !i_req_en[gnt_idx]) |-> i_biu_done
  );

endmodule
